slot_grant_scheduler: RTL and testbench

Round-robin time-slot scheduler that shares the 3-to-8 one-hot decoder resource among eight requesters. It picks one requester and drives the 3-bit select index plus the registered one-hot enable for a programmable slot length. It inserts a one-cycle guard interval between slots. It sits between the per-channel request logic and the channel/antenna enable fan-out.

---
 rtl/slot_grant_scheduler.sv | 127 ++++++++++++
 tb/tb_slot_grant_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_grant_scheduler.sv
// slot_grant_scheduler
//   Round-robin time-slot scheduler sharing one 3-to-8 one-hot enable decoder
//   among 2**IDX_W requesters. A granted requester holds the slot for a
//   programmable number of cycles (or until it drops its request, pulses its
//   release bit, or the scheduler is disabled). Every slot is followed by a
//   single guard cycle with all grant outputs low.
//
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   enable             scheduler enable; low stops new grants, ends a slot
//   req[N-1:0]         per-requester level request
//   slot_release[N-1:0] per-requester one-cycle early end-of-slot. The name
//                      differs from plain "release" because that word is a
//                      reserved keyword.
//   slot_len[SLOT_W-1:0] slot length in cycles, sampled at grant (0 acts as 1)
//   grant_valid        a slot is active
//   grant_idx          index of the granted requester
//   grant_onehot       1<<grant_idx while grant_valid, else 0
//   slot_start         pulse on the first cycle of each slot
//   idle               scheduler is in IDLE
module slot_grant_scheduler #(
  parameter int IDX_W  = 3,
  parameter int SLOT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [2**IDX_W-1:0]   req,
  input  logic [2**IDX_W-1:0]   slot_release,
  input  logic [SLOT_W-1:0]     slot_len,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [2**IDX_W-1:0]   grant_onehot,
  output logic                  slot_start,
  output logic                  idle
);
  localparam int N = 2**IDX_W;

  typedef enum logic [1:0] {IDLE, HOLD, GUARD} state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    last_idx, last_d, idx_d;
  logic [SLOT_W-1:0]   len_q, len_d, cnt, cnt_d;
  logic                start_d;

  // Round-robin search: first set request at or after last_idx+1, wrapping.
  // The index adder wraps naturally at IDX_W bits.
  logic                found;
  logic [IDX_W-1:0]    win, cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last_idx + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  logic term;
  assign term = (cnt == len_q) || slot_release[grant_idx] ||
                !req[grant_idx] || !enable;

  always_comb begin
    state_d = state;
    last_d  = last_idx;
    idx_d   = grant_idx;
    len_d   = len_q;
    cnt_d   = cnt;
    start_d = 1'b0;
    case (state)
      IDLE, GUARD: begin
        if (enable && found) begin
          state_d = HOLD;
          idx_d   = win;
          last_d  = win;
          len_d   = (slot_len == '0) ? SLOT_W'(1) : slot_len;
          cnt_d   = SLOT_W'(1);
          start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (term) state_d = GUARD;
        else      cnt_d   = cnt + SLOT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot decode of the next index, registered together with the index so
  // the enable fan-out sees a glitch-free flop output.
  logic [N-1:0] dec_d;
  for (genvar g = 0; g < N; g++) begin : g_dec
    assign dec_d[g] = (state_d == HOLD) && (idx_d == IDX_W'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_idx     <= '1;
      grant_idx    <= '0;
      len_q        <= '0;
      cnt          <= '0;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      slot_start   <= 1'b0;
      idle         <= 1'b1;
    end else begin
      state        <= state_d;
      last_idx     <= last_d;
      grant_idx    <= idx_d;
      len_q        <= len_d;
      cnt          <= cnt_d;
      grant_valid  <= (state_d == HOLD);
      grant_onehot <= dec_d;
      slot_start   <= start_d;
      idle         <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_slot_grant_scheduler.sv
module tb_slot_grant_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] req, rel;
  logic [7:0] slot_len;
  logic       grant_valid, slot_start, idle;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;

  int total = 0;
  int bad   = 0;

  slot_grant_scheduler #(.IDX_W(3), .SLOT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .slot_release(rel), .slot_len(slot_len),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_onehot(grant_onehot), .slot_start(slot_start), .idle(idle)
  );

  always #5 clk = ~clk;

  // Reference model: phase (0 idle, 1 slot, 2 guard), owner, cycles left.
  int m_phase, m_last, m_owner, m_left, m_start;

  function automatic void model_reset();
    m_phase = 0; m_last = 7; m_owner = 0; m_left = 0; m_start = 0;
  endfunction

  function automatic void model_edge(input bit en, input bit [7:0] rq,
                                     input bit [7:0] rl, input int len);
    m_start = 0;
    if (m_phase == 1) begin
      if (m_left == 1 || rl[m_owner] || !rq[m_owner] || !en) m_phase = 2;
      else m_left = m_left - 1;
    end else begin
      m_phase = 0;
      if (en && rq != 0) begin
        for (int k = 1; k <= 8; k++) begin
          if (rq[(m_last + k) % 8]) begin
            m_owner = (m_last + k) % 8;
            break;
          end
        end
        m_last  = m_owner;
        m_left  = (len == 0) ? 1 : len;
        m_phase = 1;
        m_start = 1;
      end
    end
  endfunction

  // Advance one clock; model sees the inputs as sampled at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(enable, req, rel, int'(slot_len));
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; req = '0; rel = '0; slot_len = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || idle !== 1'b1 ||
        grant_idx !== 3'd0 || slot_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b oh=%h idle=%b idx=%0d st=%b want 0 00 1 0 0",
               grant_valid, grant_onehot, idle, grant_idx, slot_start);
    end
    repeat (3) tick();
    total++;
    if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold_noreq: got v=%b oh=%h idle=%b want 0 00 1",
               grant_valid, grant_onehot, idle);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20; slot_len = 8'd4;
    for (int c = 0; c < 10; c++) begin
      bit ev, es;
      tick();
      ev = (c % 5) != 4;
      es = (c % 5) == 0;
      total++;
      if (grant_valid !== ev || slot_start !== es ||
          grant_onehot !== (ev ? 8'h20 : 8'h00) || (ev && grant_idx !== 3'd5)) begin
        bad++;
        $display("FAIL single_c%0d: got v=%b st=%b oh=%h idx=%0d want v=%b st=%b idx=5",
                 c, grant_valid, slot_start, grant_onehot, grant_idx, ev, es);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'hFF; slot_len = 8'd1;
    for (int s = 0; s < 9; s++) begin
      tick();
      total++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'(s % 8) ||
          grant_onehot !== (8'h01 << (s % 8))) begin
        bad++;
        $display("FAIL rr_slot%0d: got v=%b idx=%0d oh=%h want v=1 idx=%0d",
                 s, grant_valid, grant_idx, grant_onehot, s % 8);
      end
      tick();
      total++;
      if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || idle !== 1'b0) begin
        bad++;
        $display("FAIL rr_guard%0d: got v=%b oh=%h idle=%b want 0 00 0",
                 s, grant_valid, grant_onehot, idle);
      end
    end
  endtask

  task automatic test_early_end();
    int n0, n3;
    do_reset();
    req = 8'h09; slot_len = 8'd10;
    n0 = 0; n3 = 0;
    repeat (3) begin
      tick();
      if (grant_valid === 1'b1 && grant_idx === 3'd0) n0++;
    end
    rel = 8'h01;
    tick();
    rel = 8'h00;
    total++;
    if (n0 !== 3 || grant_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_end_slot0: got cycles=%0d v_after=%b want 3 0", n0, grant_valid);
    end
    for (int c = 0; c < 11; c++) begin
      tick();
      if (grant_valid === 1'b1 && grant_idx === 3'd3) n3++;
    end
    total++;
    if (n3 !== 10 || grant_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_end_slot3: got cycles=%0d v_end=%b want 10 0", n3, grant_valid);
    end
  endtask

  task automatic test_zero_len_enable();
    do_reset();
    req = 8'h02; slot_len = 8'd0;
    tick();
    total++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd1 || slot_start !== 1'b1) begin
      bad++;
      $display("FAIL zero_len_grant: got v=%b idx=%0d st=%b want 1 1 1",
               grant_valid, grant_idx, slot_start);
    end
    tick();
    total++;
    if (grant_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_guard: got v=%b want 0", grant_valid);
    end
    slot_len = 8'd6;
    tick();
    enable = 1'b0;
    tick();
    total++;
    if (grant_valid !== 1'b0 || idle !== 1'b0) begin
      bad++;
      $display("FAIL disable_guard: got v=%b idle=%b want 0 0", grant_valid, idle);
    end
    tick();
    total++;
    if (grant_valid !== 1'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL disable_idle: got v=%b idle=%b want 0 1", grant_valid, idle);
    end
    enable = 1'b1;
    tick();
    total++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd1) begin
      bad++;
      $display("FAIL reenable_grant: got v=%b idx=%0d want 1 1", grant_valid, grant_idx);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h40; slot_len = 8'd8;
    tick(); tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (grant_valid !== 1'b0 || grant_onehot !== 8'h00 || idle !== 1'b1 ||
        slot_start !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got v=%b oh=%h idle=%b st=%b want 0 00 1 0",
               grant_valid, grant_onehot, idle, slot_start);
    end
    rst_n = 1'b1;
    req = 8'hC0;
    tick();
    total++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd6 || grant_onehot !== 8'h40) begin
      bad++;
      $display("FAIL async_reset_regrant: got v=%b idx=%0d oh=%h want 1 6 40",
               grant_valid, grant_idx, grant_onehot);
    end
  endtask

  task automatic test_random();
    bit [7:0] eoh;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req      = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = req | 8'($urandom);
      rel      = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      slot_len = 8'($urandom_range(0, 6));
      enable   = ($urandom_range(0, 15) != 0);
      tick();
      eoh = (m_phase == 1) ? (8'h01 << m_owner) : 8'h00;
      total++;
      if (grant_valid !== (m_phase == 1) || grant_onehot !== eoh ||
          slot_start !== 1'(m_start) || idle !== (m_phase == 0) ||
          (m_phase == 1 && grant_idx !== 3'(m_owner))) begin
        bad++;
        $display("FAIL random_c%0d: got v=%b idx=%0d oh=%h st=%b idle=%b want v=%0d idx=%0d oh=%h st=%0d idle=%0d",
                 c, grant_valid, grant_idx, grant_onehot, slot_start, idle,
                 m_phase == 1, m_owner, eoh, m_start, m_phase == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_end();
    test_zero_len_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
